// File: rtl/ucore_pkg.sv
//----------------------------------------------------------------------------
// ucore_pkg
// Shared definitions for the micro-sequencer slice:
//   - seq_op encoding of the sequencing field of a micro-instruction
//   - sequencer FSM state type and state constants
// No ports; imported by ucore_useq_if, ucore_ustack and ucore_useq.
//----------------------------------------------------------------------------
package ucore_pkg;

    // Sequencing field of the micro-instruction currently at uaddr.
    typedef logic [2:0] seq_op_t;

    localparam seq_op_t OP_NEXT = 3'd0;  // uaddr + 1
    localparam seq_op_t OP_JUMP = 3'd1;  // seq_target
    localparam seq_op_t OP_BRT  = 3'd2;  // cond ? seq_target : uaddr + 1
    localparam seq_op_t OP_BRF  = 3'd3;  // cond ? uaddr + 1 : seq_target
    localparam seq_op_t OP_CALL = 3'd4;  // push uaddr + 1, go to seq_target
    localparam seq_op_t OP_RET  = 3'd5;  // pop return address
    localparam seq_op_t OP_WAIT = 3'd6;  // park until cond
    localparam seq_op_t OP_HALT = 3'd7;  // stop fetching

    // Sequencer FSM state. Plain vector constants so the encoding stays
    // visible and stable for legacy tooling that probes the state register.
    typedef logic [1:0] useq_state_t;

    localparam useq_state_t ST_HALT  = 2'd0;
    localparam useq_state_t ST_RUN   = 2'd1;
    localparam useq_state_t ST_WAIT  = 2'd2;
    localparam useq_state_t ST_FAULT = 2'd3;

endpackage : ucore_pkg

// File: rtl/ucore_useq_if.sv
//----------------------------------------------------------------------------
// ucore_useq_if
// Bundle between the core datapath (master) and the micro-sequencer (slave).
//
// Master -> slave:
//   start       leave HALT and begin fetching at the reset vector
//   stall       core not ready; sequencer holds all state
//   seq_op      sequencing op of the micro-instruction at uaddr
//   seq_target  jump / branch / call target
//   cond        condition flag from the datapath
// Slave -> master:
//   uaddr       micro-address presented to the microcode store
//   uaddr_valid uaddr is a live fetch (RUN or WAIT)
//   halted      sequencer is in HALT
//   fault       sequencer is in FAULT
//   stack_ovf   sticky: CALL attempted with the return stack full
//   stack_unf   sticky: RET attempted with the return stack empty
//   depth       current return-stack occupancy
//----------------------------------------------------------------------------
interface ucore_useq_if
    import ucore_pkg::*;
#(
    parameter int unsigned UADDR_W     = 8,
    parameter int unsigned STACK_DEPTH = 4
) ();

    localparam int unsigned DEPTH_W = $clog2(STACK_DEPTH + 1);

    logic                 start;
    logic                 stall;
    seq_op_t              seq_op;
    logic [UADDR_W-1:0]   seq_target;
    logic                 cond;

    logic [UADDR_W-1:0]   uaddr;
    logic                 uaddr_valid;
    logic                 halted;
    logic                 fault;
    logic                 stack_ovf;
    logic                 stack_unf;
    logic [DEPTH_W-1:0]   depth;

    modport master (
        output start, stall, seq_op, seq_target, cond,
        input  uaddr, uaddr_valid, halted, fault, stack_ovf, stack_unf, depth
    );

    modport slave (
        input  start, stall, seq_op, seq_target, cond,
        output uaddr, uaddr_valid, halted, fault, stack_ovf, stack_unf, depth
    );

endinterface : ucore_useq_if

// File: rtl/ucore_ustack.sv
//----------------------------------------------------------------------------
// ucore_ustack
// Parameterised LIFO holding micro-sequencer return addresses.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous active-high reset (clears occupancy only)
//   i_push       push i_push_data (ignored when full)
//   i_pop        discard the top entry (ignored when empty)
//   i_push_data  return address to push
//   o_top        entry on top of the stack (undefined when empty)
//   o_depth      number of valid entries
//   o_full       o_depth == DEPTH
//   o_empty      o_depth == 0
// The caller never asserts i_push and i_pop together.
//----------------------------------------------------------------------------
module ucore_ustack
    import ucore_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned DEPTH_W = $clog2(DEPTH + 1),
    localparam int unsigned IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_push,
    input  logic               i_pop,
    input  logic [WIDTH-1:0]   i_push_data,
    output logic [WIDTH-1:0]   o_top,
    output logic [DEPTH_W-1:0] o_depth,
    output logic               o_full,
    output logic               o_empty
);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [DEPTH_W-1:0] r_depth;

    logic               w_do_push;
    logic               w_do_pop;
    logic [DEPTH_W-1:0] w_top_ptr;
    logic [IDX_W-1:0]   w_wr_idx;
    logic [IDX_W-1:0]   w_rd_idx;

    assign o_full    = (r_depth == DEPTH_W'(DEPTH));
    assign o_empty   = (r_depth == '0);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Occupancy doubles as the write pointer; the top entry sits one below.
    // Both fit IDX_W bits whenever they are actually used (not full / not
    // empty respectively).
    assign w_top_ptr = r_depth - DEPTH_W'(1);
    assign w_wr_idx  = r_depth[IDX_W-1:0];
    assign w_rd_idx  = w_top_ptr[IDX_W-1:0];

    assign o_top   = r_mem[w_rd_idx];
    assign o_depth = r_depth;

    always_ff @(posedge clk) begin
        // NOTE: sequential state is always assigned with <= so every
        // register samples pre-edge values regardless of statement order.
        if (reset) begin
            r_depth <= '0;
        end else if (w_do_push) begin
            r_depth <= r_depth + DEPTH_W'(1);
        end else if (w_do_pop) begin
            r_depth <= w_top_ptr;
        end
    end

    // NOTE: the entry array has no reset; entries above r_depth are never
    // read, so clearing them would only cost a reset fan-out to every bit.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[w_wr_idx] <= i_push_data;
        end
    end

endmodule : ucore_ustack

// File: rtl/ucore_useq.sv
//----------------------------------------------------------------------------
// ucore_useq
// Micro-sequencer: generates the next micro-address for a microcoded core.
// FSM states HALT / RUN / WAIT / FAULT, one seq_op consumed per cycle in
// RUN, with a return stack (ucore_ustack) for CALL / RET.
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high reset, overrides every other input
//   bus    ucore_useq_if.slave (start, stall, seq_op, seq_target, cond in;
//          uaddr, uaddr_valid, halted, fault, stack_ovf, stack_unf, depth out)
//
// Parameters:
//   UADDR_W       micro-address width
//   STACK_DEPTH   number of return-stack entries
//   RESET_VECTOR  first micro-address fetched after start
//----------------------------------------------------------------------------
module ucore_useq
    import ucore_pkg::*;
#(
    parameter int unsigned UADDR_W      = 8,
    parameter int unsigned STACK_DEPTH  = 4,
    parameter int unsigned RESET_VECTOR = 0,
    localparam int unsigned DEPTH_W     = $clog2(STACK_DEPTH + 1)
) (
    input  logic         clk,
    input  logic         reset,
    ucore_useq_if.slave  bus
);

    localparam logic [UADDR_W-1:0] RST_VEC = RESET_VECTOR[UADDR_W-1:0];

    useq_state_t        r_state;
    logic [UADDR_W-1:0] r_uaddr;
    logic               r_stack_ovf;
    logic               r_stack_unf;

    useq_state_t        w_state_nxt;
    logic [UADDR_W-1:0] w_uaddr_nxt;
    logic [UADDR_W-1:0] w_uaddr_inc;
    logic               w_push;
    logic               w_pop;
    logic               w_set_ovf;
    logic               w_set_unf;
    logic [UADDR_W-1:0] w_top;
    logic [DEPTH_W-1:0] w_depth;
    logic               w_full;
    logic               w_empty;

    // Natural modulo-2^UADDR_W wrap: all-ones increments to zero.
    assign w_uaddr_inc = r_uaddr + UADDR_W'(1);

    ucore_ustack #(
        .WIDTH (UADDR_W),
        .DEPTH (STACK_DEPTH)
    ) u_ustack (
        .clk         (clk),
        .reset       (reset),
        .i_push      (w_push),
        .i_pop       (w_pop),
        .i_push_data (w_uaddr_inc),
        .o_top       (w_top),
        .o_depth     (w_depth),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    always_comb begin
        // NOTE: every signal gets a default before the case so no path
        // leaves one unassigned, which would otherwise infer a latch.
        w_state_nxt = r_state;
        w_uaddr_nxt = r_uaddr;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        w_set_ovf   = 1'b0;
        w_set_unf   = 1'b0;

        case (r_state)
            ST_HALT: begin
                if (bus.start) begin
                    w_state_nxt = ST_RUN;
                    w_uaddr_nxt = RST_VEC;
                end
            end

            ST_RUN: begin
                // stall outranks seq_op: nothing moves while the core is busy.
                if (!bus.stall) begin
                    case (bus.seq_op)
                        OP_NEXT: w_uaddr_nxt = w_uaddr_inc;
                        OP_JUMP: w_uaddr_nxt = bus.seq_target;
                        OP_BRT:  w_uaddr_nxt = bus.cond ? bus.seq_target : w_uaddr_inc;
                        OP_BRF:  w_uaddr_nxt = bus.cond ? w_uaddr_inc : bus.seq_target;
                        OP_CALL: begin
                            if (w_full) begin
                                // Stack untouched; uaddr held at the faulting CALL.
                                w_set_ovf   = 1'b1;
                                w_state_nxt = ST_FAULT;
                            end else begin
                                w_push      = 1'b1;
                                w_uaddr_nxt = bus.seq_target;
                            end
                        end
                        OP_RET: begin
                            if (w_empty) begin
                                w_set_unf   = 1'b1;
                                w_state_nxt = ST_FAULT;
                            end else begin
                                w_pop       = 1'b1;
                                w_uaddr_nxt = w_top;
                            end
                        end
                        OP_WAIT: w_state_nxt = ST_WAIT;
                        OP_HALT: begin
                            // Stack is kept so a restarted routine can still return.
                            w_state_nxt = ST_HALT;
                            w_uaddr_nxt = RST_VEC;
                        end
                        default: w_uaddr_nxt = w_uaddr_inc;
                    endcase
                end
            end

            ST_WAIT: begin
                if (!bus.stall && bus.cond) begin
                    w_state_nxt = ST_RUN;
                    w_uaddr_nxt = w_uaddr_inc;
                end
            end

            ST_FAULT: begin
                // Terminal until reset.
            end

            default: w_state_nxt = ST_FAULT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_HALT;
            r_uaddr     <= RST_VEC;
            r_stack_ovf <= 1'b0;
            r_stack_unf <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_uaddr     <= w_uaddr_nxt;
            r_stack_ovf <= r_stack_ovf | w_set_ovf;
            r_stack_unf <= r_stack_unf | w_set_unf;
        end
    end

    assign bus.uaddr       = r_uaddr;
    assign bus.uaddr_valid = (r_state == ST_RUN) || (r_state == ST_WAIT);
    assign bus.halted      = (r_state == ST_HALT);
    assign bus.fault       = (r_state == ST_FAULT);
    assign bus.stack_ovf   = r_stack_ovf;
    assign bus.stack_unf   = r_stack_unf;
    assign bus.depth       = w_depth;

endmodule : ucore_useq

// File: tb/tb_ucore_useq.sv
//----------------------------------------------------------------------------
// tb_ucore_useq
// Directed self-checking bench for ucore_useq (UADDR_W=8, STACK_DEPTH=4,
// RESET_VECTOR=0). Inputs change 1 time unit after the rising edge and
// outputs are sampled at that same point, well away from the next edge.
//----------------------------------------------------------------------------
module tb_ucore_useq;
    import ucore_pkg::*;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    ucore_useq_if #(.UADDR_W(8), .STACK_DEPTH(4)) bus ();

    ucore_useq #(
        .UADDR_W      (8),
        .STACK_DEPTH  (4),
        .RESET_VECTOR (0)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input seq_op_t op, input logic [7:0] tgt, input logic c);
        bus.seq_op     = op;
        bus.seq_target = tgt;
        bus.cond       = c;
        tick();
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        bus.start      = 1'b0;
        bus.stall      = 1'b0;
        bus.seq_op     = OP_NEXT;
        bus.seq_target = '0;
        bus.cond       = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic restart();
        do_reset();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (bus.uaddr !== 8'h00) begin n_errors++; $display("FAIL reset_uaddr: got %0h expected 0", bus.uaddr); end
        n_checks++;
        if ({bus.uaddr_valid, bus.halted, bus.fault} !== 3'b010) begin
            n_errors++; $display("FAIL reset_flags: valid/halted/fault got %b expected 010", {bus.uaddr_valid, bus.halted, bus.fault});
        end
        n_checks++;
        if ({bus.stack_ovf, bus.stack_unf, bus.depth} !== 5'b00000) begin
            n_errors++; $display("FAIL reset_stack: ovf/unf/depth got %b expected 00000", {bus.stack_ovf, bus.stack_unf, bus.depth});
        end
        // Without start the block stays halted whatever seq_op says.
        drive(OP_JUMP, 8'h33, 1'b1);
        n_checks++;
        if (bus.halted !== 1'b1 || bus.uaddr !== 8'h00) begin
            n_errors++; $display("FAIL halt_no_start: halted=%b uaddr=%0h expected 1/0", bus.halted, bus.uaddr);
        end
    endtask

    task automatic test_next();
        restart();
        n_checks++;
        if (bus.uaddr !== 8'h00 || bus.uaddr_valid !== 1'b1 || bus.halted !== 1'b0) begin
            n_errors++; $display("FAIL start: uaddr=%0h valid=%b halted=%b expected 0/1/0", bus.uaddr, bus.uaddr_valid, bus.halted);
        end
        for (int i = 1; i <= 3; i++) begin
            drive(OP_NEXT, 8'h00, 1'b0);
            n_checks++;
            if (bus.uaddr !== 8'(i)) begin n_errors++; $display("FAIL next_seq: got %0h expected %0h", bus.uaddr, i); end
        end
        // start while running is ignored: NEXT still just increments.
        bus.start = 1'b1;
        drive(OP_NEXT, 8'h00, 1'b0);
        bus.start = 1'b0;
        n_checks++;
        if (bus.uaddr !== 8'h04) begin n_errors++; $display("FAIL start_in_run: got %0h expected 4", bus.uaddr); end
    endtask

    task automatic test_jump_branch();
        seq_op_t    ops [5] = '{OP_JUMP, OP_BRT, OP_BRF, OP_BRT, OP_BRF};
        logic [7:0] tgt [5] = '{8'h40, 8'h10, 8'h20, 8'h33, 8'h55};
        logic       cnd [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [7:0] exp [5] = '{8'h40, 8'h41, 8'h20, 8'h33, 8'h34};
        restart();
        for (int i = 0; i < 5; i++) begin
            drive(ops[i], tgt[i], cnd[i]);
            n_checks++;
            if (bus.uaddr !== exp[i]) begin n_errors++; $display("FAIL branch_%0d: got %0h expected %0h", i, bus.uaddr, exp[i]); end
        end
    endtask

    task automatic test_call_ret();
        seq_op_t    ops [3]  = '{OP_CALL, OP_NEXT, OP_RET};
        logic [7:0] exp_u [3] = '{8'h80, 8'h81, 8'h06};
        logic [2:0] exp_d [3] = '{3'd1, 3'd1, 3'd0};
        restart();
        drive(OP_JUMP, 8'h05, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(ops[i], 8'h80, 1'b0);
            n_checks++;
            if (bus.uaddr !== exp_u[i] || bus.depth !== exp_d[i]) begin
                n_errors++; $display("FAIL call_ret_%0d: uaddr=%0h depth=%0d expected %0h/%0d", i, bus.uaddr, bus.depth, exp_u[i], exp_d[i]);
            end
        end
    endtask

    task automatic test_overflow();
        restart();
        for (int i = 1; i <= 4; i++) begin
            drive(OP_CALL, 8'h10, 1'b0);
            n_checks++;
            if (bus.depth !== 3'(i) || bus.fault !== 1'b0) begin
                n_errors++; $display("FAIL call_nest_%0d: depth=%0d fault=%b expected %0d/0", i, bus.depth, bus.fault, i);
            end
        end
        drive(OP_CALL, 8'h10, 1'b0);
        n_checks++;
        if ({bus.fault, bus.stack_ovf, bus.uaddr_valid, bus.stack_unf} !== 4'b1100) begin
            n_errors++; $display("FAIL ovf_flags: fault/ovf/valid/unf got %b expected 1100", {bus.fault, bus.stack_ovf, bus.uaddr_valid, bus.stack_unf});
        end
        n_checks++;
        if (bus.depth !== 3'd4 || bus.uaddr !== 8'h10) begin
            n_errors++; $display("FAIL ovf_hold: depth=%0d uaddr=%0h expected 4/10", bus.depth, bus.uaddr);
        end
        // FAULT persists through start and further ops.
        bus.start = 1'b1;
        drive(OP_NEXT, 8'h00, 1'b1);
        drive(OP_RET, 8'h00, 1'b1);
        bus.start = 1'b0;
        n_checks++;
        if (bus.fault !== 1'b1 || bus.stack_ovf !== 1'b1 || bus.uaddr !== 8'h10 || bus.depth !== 3'd4) begin
            n_errors++; $display("FAIL fault_persist: fault=%b ovf=%b uaddr=%0h depth=%0d expected 1/1/10/4", bus.fault, bus.stack_ovf, bus.uaddr, bus.depth);
        end
    endtask

    task automatic test_underflow();
        restart();
        n_checks++;
        if (bus.stack_ovf !== 1'b0 || bus.fault !== 1'b0) begin
            n_errors++; $display("FAIL ovf_cleared: ovf=%b fault=%b expected 0/0", bus.stack_ovf, bus.fault);
        end
        drive(OP_RET, 8'h00, 1'b0);
        n_checks++;
        if ({bus.fault, bus.stack_unf, bus.stack_ovf, bus.uaddr_valid} !== 4'b1100) begin
            n_errors++; $display("FAIL unf_flags: fault/unf/ovf/valid got %b expected 1100", {bus.fault, bus.stack_unf, bus.stack_ovf, bus.uaddr_valid});
        end
        n_checks++;
        if (bus.depth !== 3'd0 || bus.uaddr !== 8'h00) begin
            n_errors++; $display("FAIL unf_hold: depth=%0d uaddr=%0h expected 0/0", bus.depth, bus.uaddr);
        end
    endtask

    task automatic test_wait_stall();
        restart();
        drive(OP_JUMP, 8'h10, 1'b0);
        drive(OP_WAIT, 8'h00, 1'b0);
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (bus.uaddr !== 8'h10 || bus.uaddr_valid !== 1'b1) begin
                n_errors++; $display("FAIL wait_hold_%0d: uaddr=%0h valid=%b expected 10/1", i, bus.uaddr, bus.uaddr_valid);
            end
            // seq_op is ignored while waiting.
            drive(OP_JUMP, 8'h77, 1'b0);
        end
        drive(OP_NEXT, 8'h00, 1'b1);
        n_checks++;
        if (bus.uaddr !== 8'h11) begin n_errors++; $display("FAIL wait_release: got %0h expected 11", bus.uaddr); end
        bus.stall = 1'b1;
        drive(OP_JUMP, 8'h99, 1'b1);
        drive(OP_CALL, 8'h99, 1'b1);
        n_checks++;
        if (bus.uaddr !== 8'h11 || bus.depth !== 3'd0) begin
            n_errors++; $display("FAIL stall_run: uaddr=%0h depth=%0d expected 11/0", bus.uaddr, bus.depth);
        end
        bus.stall = 1'b0;
        drive(OP_NEXT, 8'h00, 1'b0);
        n_checks++;
        if (bus.uaddr !== 8'h12) begin n_errors++; $display("FAIL stall_resume: got %0h expected 12", bus.uaddr); end
        // stall outranks cond inside WAIT too.
        drive(OP_WAIT, 8'h00, 1'b0);
        bus.stall = 1'b1;
        drive(OP_NEXT, 8'h00, 1'b1);
        n_checks++;
        if (bus.uaddr !== 8'h12) begin n_errors++; $display("FAIL stall_wait: got %0h expected 12", bus.uaddr); end
        bus.stall = 1'b0;
        drive(OP_NEXT, 8'h00, 1'b1);
        n_checks++;
        if (bus.uaddr !== 8'h13) begin n_errors++; $display("FAIL stall_wait_release: got %0h expected 13", bus.uaddr); end
    endtask

    task automatic test_halt_op();
        restart();
        drive(OP_CALL, 8'h40, 1'b0);
        drive(OP_HALT, 8'h00, 1'b0);
        n_checks++;
        if ({bus.halted, bus.uaddr_valid} !== 2'b10 || bus.uaddr !== 8'h00 || bus.depth !== 3'd1) begin
            n_errors++; $display("FAIL halt_op: halted=%b valid=%b uaddr=%0h depth=%0d expected 1/0/0/1", bus.halted, bus.uaddr_valid, bus.uaddr, bus.depth);
        end
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        // The return address pushed before HALT survives the restart.
        drive(OP_RET, 8'h00, 1'b0);
        n_checks++;
        if (bus.uaddr !== 8'h01 || bus.depth !== 3'd0 || bus.fault !== 1'b0) begin
            n_errors++; $display("FAIL halt_restart_ret: uaddr=%0h depth=%0d fault=%b expected 1/0/0", bus.uaddr, bus.depth, bus.fault);
        end
    endtask

    task automatic test_wrap_and_reset();
        restart();
        drive(OP_JUMP, 8'hFF, 1'b0);
        drive(OP_NEXT, 8'h00, 1'b0);
        n_checks++;
        if (bus.uaddr !== 8'h00 || bus.fault !== 1'b0) begin
            n_errors++; $display("FAIL wrap: uaddr=%0h fault=%b expected 0/0", bus.uaddr, bus.fault);
        end
        drive(OP_CALL, 8'h20, 1'b0);
        drive(OP_CALL, 8'h30, 1'b0);
        drive(OP_WAIT, 8'h00, 1'b0);
        n_checks++;
        if (bus.depth !== 3'd2 || bus.uaddr !== 8'h30) begin
            n_errors++; $display("FAIL pre_reset: depth=%0d uaddr=%0h expected 2/30", bus.depth, bus.uaddr);
        end
        reset     = 1'b1;
        bus.stall = 1'b1;
        bus.start = 1'b1;
        bus.cond  = 1'b1;
        tick();
        n_checks++;
        if ({bus.halted, bus.uaddr_valid, bus.fault} !== 3'b100 || bus.depth !== 3'd0 || bus.uaddr !== 8'h00) begin
            n_errors++; $display("FAIL mid_reset: halted/valid/fault=%b depth=%0d uaddr=%0h expected 100/0/0",
                                 {bus.halted, bus.uaddr_valid, bus.fault}, bus.depth, bus.uaddr);
        end
        reset     = 1'b0;
        bus.stall = 1'b0;
        bus.start = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b1;
        test_reset();
        test_next();
        test_jump_branch();
        test_call_ret();
        test_overflow();
        test_underflow();
        test_wait_stall();
        test_halt_op();
        test_wrap_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_ucore_useq
